rv32i_inst_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of `control_unit` decoding. Accepts instruction fields (format, opcode, funct3, funct7, registers, immediate) over a valid/ready handshake, packs them into 32-bit instruction words through a 2-entry pipeline, and writes them to sequential instruction-memory addresses. Used by the self-test loader to build programs in `imem` at run time.

---
 rtl/rv32i_inst_encoder.sv | 153 +++++++++++++++
 tb/tb_rv32i_inst_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_inst_encoder.sv
// Streaming RV32I instruction encoder: packs field bundles into instruction words and writes them
// to sequential imem addresses through a 2-entry pipeline. Define RV_ENC_CHECK_EN to reject illegal bundles.
module rv32i_inst_encoder #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W:0]   CAP   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] CAP_X = {2'b01, {ADDR_W{1'b0}}};

  function automatic logic [31:0] pack_word(
    input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] w;
    case (fmt)
      3'd1: begin
        // Shift-immediates carry funct7 above the 5-bit shamt
        if (op == 7'b0010011 && (f3 == 3'b001 || f3 == 3'b101)) begin
          w = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          w = {imm[11:0], rs1, f3, rd, op};
        end
      end
      3'd2:    w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd3:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      3'd4:    w = {imm[31:12], rd, op};
      3'd5:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = {f7, rs2, rs1, f3, rd, op};
    endcase
    return w;
  endfunction

  logic        e_valid_r;
  logic [31:0] e_word_r;
  logic        e_adv_s;
  logic        commit_s;
  logic        accept_s;
  logic        illegal_s;
  logic        room_s;
  logic [1:0]  inflight_s;
  logic [ADDR_W:0] count_nxt_s;

  // Handshake, advance and capacity decisions for the current cycle
  always_comb begin
    e_adv_s     = e_valid_r && (!imem_we || imem_ready);
    commit_s    = imem_we && imem_ready;
    inflight_s  = {1'b0, e_valid_r} + {1'b0, imem_we};
    room_s      = ({1'b0, count} + {{ADDR_W{1'b0}}, inflight_s}) < CAP_X;
    in_ready    = !rst && !clear && (!e_valid_r || e_adv_s) && room_s;
    accept_s    = in_valid && in_ready;
    count_nxt_s = commit_s ? (count + (ADDR_W+1)'(1'b1)) : count;
  end

  // Encode (E) and output (O) stages plus address/count bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid_r  <= 1'b0;
      e_word_r   <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      count      <= {(ADDR_W+1){1'b0}};
      full       <= 1'b0;
    end else if (clear) begin
      e_valid_r  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      count      <= {(ADDR_W+1){1'b0}};
      full       <= 1'b0;
    end else begin
      if (commit_s) begin
        imem_addr <= imem_addr + ADDR_W'(1'b1);
      end
      count <= count_nxt_s;
      full  <= (count_nxt_s == CAP);
      if (e_adv_s) begin
        imem_we    <= 1'b1;
        imem_wdata <= e_word_r;
      end else if (commit_s) begin
        imem_we <= 1'b0;
      end
      // Illegal bundles are consumed here and never enter the pipeline
      if (accept_s && !illegal_s) begin
        e_valid_r <= 1'b1;
        e_word_r  <= pack_word(in_fmt, in_opcode, in_funct3, in_funct7,
                               in_rd, in_rs1, in_rs2, in_imm);
      end else if (e_adv_s) begin
        e_valid_r <= 1'b0;
      end
    end
  end

`ifdef RV_ENC_CHECK_EN
  function automatic logic bundle_illegal(
    input logic [2:0] fmt, input logic [6:0] op, input logic [31:0] imm);
    logic bad;
    logic is_i_s;
    logic is_b;
    logic is_j;
    is_i_s = (fmt == 3'd1) || (fmt == 3'd2);
    is_b   = (fmt == 3'd3);
    is_j   = (fmt == 3'd5);
    bad = (fmt > 3'd5) || (op[1:0] != 2'b11);
    bad = bad || ((is_b || is_j) && imm[0]);
    bad = bad || (is_i_s && imm[31:11] != {21{1'b0}} && imm[31:11] != {21{1'b1}});
    bad = bad || (is_b && imm[31:12] != {20{1'b0}} && imm[31:12] != {20{1'b1}});
    bad = bad || (is_j && imm[31:20] != {12{1'b0}} && imm[31:20] != {12{1'b1}});
    return bad;
  endfunction

  assign illegal_s = bundle_illegal(in_fmt, in_opcode, in_imm);

  // Sticky error flag and saturating count; survives clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= 8'd0;
    end else if (accept_s && illegal_s) begin
      err <= 1'b1;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign illegal_s = 1'b0;
  assign err       = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder: a 1K-word instance at base 16 and a 4-word instance at base 1.
module tb_rv32i_inst_encoder;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear_a, clear_b;
  logic        in_valid_a, in_valid_b, imem_ready_a, imem_ready_b;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready_a, imem_we_a, full_a, err_a;
  logic [9:0]  imem_addr_a;
  logic [31:0] imem_wdata_a;
  logic [10:0] count_a;
  logic [7:0]  err_count_a;

  logic        in_ready_b, imem_we_b, full_b, err_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [2:0]  count_b;
  logic [7:0]  err_count_b;

  rv32i_inst_encoder #(.ADDR_W(10), .BASE_ADDR(10'd16)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
    .imem_ready(imem_ready_a), .count(count_a), .full(full_a), .err(err_a), .err_count(err_count_a));

  rv32i_inst_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .imem_ready(imem_ready_b), .count(count_b), .full(full_b), .err(err_b), .err_count(err_count_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  int qa_cyc[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write log, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (imem_we_a && imem_ready_a) begin
      qa_addr.push_back({22'd0, imem_addr_a});
      qa_data.push_back(imem_wdata_a);
      qa_cyc.push_back(cyc);
    end
    if (imem_we_b && imem_ready_b) begin
      qb_addr.push_back({30'd0, imem_addr_b});
      qb_data.push_back(imem_wdata_b);
    end
  end

  task automatic wait_accept(input bit sel);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = sel ? in_ready_b : in_ready_a;
      @(posedge clk);
      #1;
    end
    if (!got) check_eq("accept_timeout", 32'd0, 32'd1);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  task automatic send(input bit sel, input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    set_fields(fmt, op, f3, f7, rd, rs1, rs2, imm);
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    wait_accept(sel);
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_words[10];
  int n_exp;

  initial begin
    exp_words = '{32'h002081B3, 32'h00500093, 32'h0020A423, 32'hFE208EE3, 32'h001000EF,
                  32'h123452B7, 32'h4032D293, 32'h002081B3, 32'h00500093, 32'h123452B7};
    rst = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; imem_ready_a = 1'b1; imem_ready_b = 1'b1;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready_a, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready_after", in_ready_a, 32'd1);
    check_eq("rst_we", imem_we_a, 32'd0);
    check_eq("rst_addr", imem_addr_a, 32'd16);
    check_eq("rst_wdata", imem_wdata_a, 32'd0);
    check_eq("rst_count", count_a, 32'd0);
    check_eq("rst_full", full_a, 32'd0);
    check_eq("rst_err", err_a, 32'd0);
    check_eq("rst_err_count", err_count_a, 32'd0);
    check_eq("rst_b_addr", imem_addr_b, 32'd1);
    check_eq("rst_b_err", {24'd0, err_count_b} | {31'd0, err_b}, 32'd0);
    @(posedge clk); #1;

    // ADD with two-cycle latency, then ADDI
    send(1'b0, 3'd0, OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    check_eq("lat_e_stage", imem_we_a, 32'd0);
    @(negedge clk);
    check_eq("lat_we", imem_we_a, 32'd1);
    check_eq("lat_data", imem_wdata_a, 32'h002081B3);
    @(posedge clk); #1;
    send(1'b0, 3'd1, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    check_eq("count_two", count_a, 32'd2);

    // Back-to-back S, B, J then U and shift-immediate
    send(1'b0, 3'd2, OP_ST, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send(1'b0, 3'd3, OP_BR, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    send(1'b0, 3'd5, OP_JAL, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    send(1'b0, 3'd4, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    send(1'b0, 3'd1, OP_IMM, 3'b101, 7'b0100000, 5'd5, 5'd5, 5'd0, 32'd3);
    drain();
    if (qa_cyc.size() >= 5) begin
      check_eq("b2b_gap1", qa_cyc[3] - qa_cyc[2], 32'd1);
      check_eq("b2b_gap2", qa_cyc[4] - qa_cyc[3], 32'd1);
    end else begin
      check_eq("b2b_writes", qa_cyc.size(), 32'd5);
    end

    // Backpressure: two accepts, third held off, first word stable
    imem_ready_a = 1'b0;
    send(1'b0, 3'd0, OP_R, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    send(1'b0, 3'd1, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    set_fields(3'd4, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready_a, 32'd0);
      check_eq("bp_we", imem_we_a, 32'd1);
      check_eq("bp_addr", imem_addr_a, 32'd23);
      check_eq("bp_data", imem_wdata_a, 32'h002081B3);
    end
    @(posedge clk); #1;
    imem_ready_a = 1'b1;
    wait_accept(1'b0);
    drain();
    check_eq("bp_count", count_a, 32'd10);

    check_eq("log_size", qa_data.size(), 32'd10);
    n_exp = (qa_data.size() < 10) ? qa_data.size() : 10;
    for (int i = 0; i < n_exp; i++) begin
      check_eq($sformatf("word%0d_addr", i), qa_addr[i], 32'd16 + i);
      check_eq($sformatf("word%0d_data", i), qa_data[i], exp_words[i]);
    end

`ifdef RV_ENC_CHECK_EN
    // Misaligned branch offset is consumed without a write
    send(1'b0, 3'd3, OP_BR, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    drain();
    check_eq("chk_err", err_a, 32'd1);
    check_eq("chk_err_count", err_count_a, 32'd1);
    check_eq("chk_no_write", qa_data.size(), 32'd10);
    send(1'b0, 3'd1, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    check_eq("chk_after_size", qa_data.size(), 32'd11);
    if (qa_data.size() == 11) begin
      check_eq("chk_after_addr", qa_addr[10], 32'd26);
      check_eq("chk_after_data", qa_data[10], 32'h00500093);
    end
`else
    check_eq("nochk_err", err_a, 32'd0);
    check_eq("nochk_err_count", err_count_a, 32'd0);
`endif

    // Small instance: fill, wrap, full, clear
    for (int i = 1; i <= 4; i++) begin
      send(1'b1, 3'd1, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, i);
    end
    drain();
    check_eq("full_flag", full_b, 32'd1);
    check_eq("full_in_ready", in_ready_b, 32'd0);
    check_eq("full_count", count_b, 32'd4);
    check_eq("full_log_size", qb_data.size(), 32'd4);
    for (int i = 0; i < 4 && i < qb_data.size(); i++) begin
      check_eq($sformatf("fill%0d_addr", i), qb_addr[i], (i + 1) % 4);
      check_eq($sformatf("fill%0d_data", i), qb_data[i], ((i + 1) << 20) | 32'h93);
    end
    clear_b = 1'b1;
    @(negedge clk);
    check_eq("clear_in_ready", in_ready_b, 32'd0);
    @(posedge clk); #1;
    clear_b = 1'b0;
    @(negedge clk);
    check_eq("clear_full", full_b, 32'd0);
    check_eq("clear_count", count_b, 32'd0);
    check_eq("clear_addr", imem_addr_b, 32'd1);
    @(posedge clk); #1;
    send(1'b1, 3'd1, OP_IMM, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    check_eq("post_clear_size", qb_data.size(), 32'd5);
    if (qb_data.size() == 5) begin
      check_eq("post_clear_addr", qb_addr[4], 32'd1);
      check_eq("post_clear_data", qb_data[4], 32'h00500093);
    end
    check_eq("post_clear_count", count_b, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
